// File: rtl/s38417_pkg.sv
// s38417_pkg: shared constants, state encoding and helpers for the three-bank
// 9-bit match sequencer and its word compare datapath.
package s38417_pkg;

   localparam int unsigned W     = 9;
   localparam int unsigned NBANK = 3;
   localparam logic [1:0]  NO_HIT = 2'd3;

   // Scan sequencer states (IDLE, SCAN, DONE)
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_SCAN = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // One-hot bank select for bank index 0..2; index 3 yields no select
   function automatic logic [NBANK-1:0] onehot3(input logic [1:0] idx);
      return 3'b001 << idx;
   endfunction

   // Lowest set bank wins (A = 0); NO_HIT when nothing is set
   function automatic logic [1:0] prio_enc3(input logic [NBANK-1:0] v);
      logic [1:0] r;
      r = NO_HIT;
      if (v[2]) r = 2'd2;
      if (v[1]) r = 2'd1;
      if (v[0]) r = 2'd0;
      return r;
   endfunction

endpackage

// File: rtl/s38417_word_cmp.sv
// s38417_word_cmp: one-hot 3:1 word mux followed by a W-bit equality compare.
// Ports:
//   sel_i               one-hot bank select (bit0 = A)
//   word_a/b/c_i        stored words of banks A/B/C
//   key_i               compare word
//   match_c             combinational: selected word equals key
module s38417_word_cmp
   import s38417_pkg::*;
(
   input  logic [NBANK-1:0] sel_i,
   input  logic [W-1:0]     word_a_i,
   input  logic [W-1:0]     word_b_i,
   input  logic [W-1:0]     word_c_i,
   input  logic [W-1:0]     key_i,
   output logic             match_c
);

   logic [W-1:0] mux_word;

   // AND-OR mux; select is guaranteed one-hot or zero by the sequencer
   always_comb begin
      mux_word = ({W{sel_i[0]}} & word_a_i)
               | ({W{sel_i[1]}} & word_b_i)
               | ({W{sel_i[2]}} & word_c_i);
      match_c  = (mux_word == key_i);
   end

endmodule

// File: rtl/s38417_bank_scan_ctrl.sv
// s38417_bank_scan_ctrl: sweeps a one-hot select across banks A/B/C on a start
// request, records per-bank key hits, then publishes hit vector, lowest hit
// index and a sticky, enable-qualified result flag.
// Ports:
//   CK, RST             clock (rising edge), asynchronous active-high reset
//   start               scan request, honoured in IDLE only
//   freeze              stall: holds state and every register
//   upd_en_a/b          flag update qualifiers (AND-ed)
//   bank_vld            per-bank valid, bit0 = A
//   bank_a/b/c, key     stored words and compare word
//   sel, busy           decoded from registered state
//   done                one-cycle end-of-scan pulse, suppressed while frozen
//   hit_vec, first_hit  results of the last completed scan
//   flag                sticky result register
module s38417_bank_scan_ctrl
   import s38417_pkg::*;
(
   input  logic             CK,
   input  logic             RST,
   input  logic             start,
   input  logic             freeze,
   input  logic             upd_en_a,
   input  logic             upd_en_b,
   input  logic [NBANK-1:0] bank_vld,
   input  logic [W-1:0]     bank_a,
   input  logic [W-1:0]     bank_b,
   input  logic [W-1:0]     bank_c,
   input  logic [W-1:0]     key,
   output logic [NBANK-1:0] sel,
   output logic             busy,
   output logic             done,
   output logic [NBANK-1:0] hit_vec,
   output logic [1:0]       first_hit,
   output logic             flag
);

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [NBANK-1:0] whit_q, whit_d;
   logic [NBANK-1:0] hit_vec_q, hit_vec_d;
   logic [1:0]       first_hit_q, first_hit_d;
   logic             flag_q, flag_d;
   logic [NBANK-1:0] sel_c;
   logic             match_c;

   // Select decoded from registered state so the datapath sees no glitches
   always_comb begin
      sel_c = '0;
      if (state_q == ST_SCAN) sel_c = onehot3(idx_q);
   end

   s38417_word_cmp u_word_cmp (
      .sel_i    (sel_c),
      .word_a_i (bank_a),
      .word_b_i (bank_b),
      .word_c_i (bank_c),
      .key_i    (key),
      .match_c  (match_c)
   );

   // State and result registers
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         idx_q       <= 2'd0;
         whit_q      <= '0;
         hit_vec_q   <= '0;
         first_hit_q <= NO_HIT;
         flag_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         whit_q      <= whit_d;
         hit_vec_q   <= hit_vec_d;
         first_hit_q <= first_hit_d;
         flag_q      <= flag_d;
      end
   end

   // Next-state and result update; freeze leaves every default in place
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      whit_d      = whit_q;
      hit_vec_d   = hit_vec_q;
      first_hit_d = first_hit_q;
      flag_d      = flag_q;
      if (!freeze) begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  idx_d   = 2'd0;
                  whit_d  = '0;
                  state_d = ST_SCAN;
               end
            end
            ST_SCAN: begin
               // Rewrite only the selected bank's hit bit; invalid banks never hit
               whit_d = (whit_q & ~sel_c) | (sel_c & bank_vld & {NBANK{match_c}});
               if (idx_q == 2'd2) state_d = ST_DONE;
               else               idx_d   = idx_q + 2'd1;
            end
            ST_DONE: begin
               hit_vec_d   = whit_q;
               first_hit_d = prio_enc3(whit_q);
               if (upd_en_a && upd_en_b) flag_d = |whit_q;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign sel       = sel_c;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE) && !freeze;
   assign hit_vec   = hit_vec_q;
   assign first_hit = first_hit_q;
   assign flag      = flag_q;

endmodule

// File: tb/tb_s38417_bank_scan_ctrl.sv
// tb_s38417_bank_scan_ctrl: directed and randomized scans of the bank scan
// sequencer, checked cycle by cycle against a behavioural expectation built
// from the bank/key words, valid mask, enables and freeze placement.
module tb_s38417_bank_scan_ctrl;

   logic       CK;
   logic       RST;
   logic       start;
   logic       freeze;
   logic       upd_en_a;
   logic       upd_en_b;
   logic [2:0] bank_vld;
   logic [8:0] bank_a;
   logic [8:0] bank_b;
   logic [8:0] bank_c;
   logic [8:0] key;
   logic [2:0] sel;
   logic       busy;
   logic       done;
   logic [2:0] hit_vec;
   logic [1:0] first_hit;
   logic       flag;

   int vectors    = 0;
   int miscompares = 0;

   // Model of the published results
   logic [2:0] hit_m;
   logic [1:0] fh_m;
   logic       flag_m;

   s38417_bank_scan_ctrl dut (
      .CK        (CK),
      .RST       (RST),
      .start     (start),
      .freeze    (freeze),
      .upd_en_a  (upd_en_a),
      .upd_en_b  (upd_en_b),
      .bank_vld  (bank_vld),
      .bank_a    (bank_a),
      .bank_b    (bank_b),
      .bank_c    (bank_c),
      .key       (key),
      .sel       (sel),
      .busy      (busy),
      .done      (done),
      .hit_vec   (hit_vec),
      .first_hit (first_hit),
      .flag      (flag)
   );

   initial begin
      CK = 1'b0;
      forever #5 CK = ~CK;
   end

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge CK);
      #1;
   endtask

   task automatic chk_res(input string tag);
      chk({tag, ".hit_vec"},   9'(hit_vec),   9'(hit_m));
      chk({tag, ".first_hit"}, 9'(first_hit), 9'(fh_m));
      chk({tag, ".flag"},      9'(flag),      9'(flag_m));
   endtask

   task automatic chk_ctl(input string tag, input logic [2:0] s, input logic b, input logic d);
      chk({tag, ".sel"},  9'(sel),  9'(s));
      chk({tag, ".busy"}, 9'(busy), 9'(b));
      chk({tag, ".done"}, 9'(done), 9'(d));
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         start  = 1'b0;
         freeze = 1'b0;
         #1;
         chk_ctl("idle", 3'b000, 1'b0, 1'b0);
         chk_res("idle");
      end
   endtask

   // One complete scan. frz_bank: bank 0..2 or 3 (= DONE cycle) frozen for
   // frz_len cycles, anything else for no freeze. smode: 0 start pulse only,
   // 1 start held throughout, 2 extra start pulse during the scan.
   task automatic run_scan(input logic [2:0] vld, input logic [8:0] a, input logic [8:0] b,
                           input logic [8:0] c, input logic [8:0] k, input logic ua,
                           input logic ub, input int frz_bank, input int frz_len, input int smode);
      logic [8:0] words [3];
      logic [2:0] exp_hit;
      logic [1:0] exp_fh;
      logic [2:0] exp_sel;
      logic       fz;
      int         reps;
      words   = '{a, b, c};
      exp_hit = 3'b000;
      exp_fh  = 2'd3;
      for (int i = 0; i < 3; i++)
         if (vld[i] && words[i] == k) exp_hit[i] = 1'b1;
      for (int i = 2; i >= 0; i--)
         if (exp_hit[i]) exp_fh = 2'(i);

      // Request cycle: still IDLE, previous results visible
      cyc();
      start    = 1'b1;
      freeze   = 1'b0;
      bank_vld = vld;
      bank_a   = a;
      bank_b   = b;
      bank_c   = c;
      key      = k;
      upd_en_a = ua;
      upd_en_b = ub;
      #1;
      chk_ctl("req", 3'b000, 1'b0, 1'b0);
      chk_res("req");

      for (int bk = 0; bk <= 3; bk++) begin
         reps = (bk == frz_bank) ? frz_len + 1 : 1;
         for (int f = 0; f < reps; f++) begin
            fz = (f < reps - 1);
            cyc();
            freeze = fz;
            start  = (smode == 1) || (smode == 2 && bk == 1 && f == 0);
            #1;
            if (bk < 3) begin
               exp_sel = 3'b001 << bk;
               chk_ctl("scan", exp_sel, 1'b1, 1'b0);
            end else begin
               chk_ctl("done", 3'b000, 1'b1, !fz);
            end
            chk_res("hold");
         end
      end

      hit_m = exp_hit;
      fh_m  = exp_fh;
      if (ua && ub) flag_m = |exp_hit;
      freeze = 1'b0;
      if (smode != 1) start = 1'b0;
   endtask

   initial begin
      logic [8:0] k;
      logic [8:0] w [3];
      RST      = 1'b1;
      start    = 1'b0;
      freeze   = 1'b0;
      upd_en_a = 1'b0;
      upd_en_b = 1'b0;
      bank_vld = 3'b000;
      bank_a   = '0;
      bank_b   = '0;
      bank_c   = '0;
      key      = '0;
      hit_m    = 3'b000;
      fh_m     = 2'd3;
      flag_m   = 1'b0;

      #1;
      chk_ctl("reset", 3'b000, 1'b0, 1'b0);
      chk_res("reset");
      cyc();
      RST = 1'b0;
      idle_cycles(2);

      // Match in bank A only
      run_scan(3'b111, 9'h1A5, 9'h000, 9'h1FF, 9'h1A5, 1'b1, 1'b1, -1, 0, 0);
      // No hit with one qualifier low: flag holds at 1
      run_scan(3'b111, 9'h001, 9'h002, 9'h003, 9'h0AA, 1'b1, 1'b0, -1, 0, 0);
      // Valid masking: bank B matches but is invalid
      run_scan(3'b101, 9'h123, 9'h0F0, 9'h0F1, 9'h0F0, 1'b1, 1'b1, -1, 0, 0);
      // Two-cycle freeze on bank B, hits in B and C
      run_scan(3'b111, 9'h010, 9'h155, 9'h155, 9'h155, 1'b1, 1'b1, 1, 2, 0);
      // Freeze on the DONE cycle delays the done pulse
      run_scan(3'b100, 9'h044, 9'h044, 9'h044, 9'h044, 1'b1, 1'b1, 3, 1, 0);
      // Back-to-back with start held, all banks equal the key
      run_scan(3'b111, 9'h0C3, 9'h0C3, 9'h0C3, 9'h0C3, 1'b1, 1'b1, -1, 0, 1);
      run_scan(3'b111, 9'h0C3, 9'h0C3, 9'h0C3, 9'h0C3, 1'b1, 1'b1, -1, 0, 1);
      // Start pulse inside the scan is not queued
      run_scan(3'b111, 9'h0C3, 9'h0C3, 9'h0C3, 9'h0C3, 1'b1, 1'b1, -1, 0, 2);
      idle_cycles(3);

      // Asynchronous reset during bank C, flag currently 1
      cyc();
      start    = 1'b1;
      bank_vld = 3'b111;
      key      = 9'h0C3;
      #1;
      chk_ctl("rreq", 3'b000, 1'b0, 1'b0);
      for (int bk = 0; bk < 3; bk++) begin
         cyc();
         start = 1'b0;
         #1;
         chk_ctl("rscan", 3'(3'b001 << bk), 1'b1, 1'b0);
      end
      #2;
      RST    = 1'b1;
      hit_m  = 3'b000;
      fh_m   = 2'd3;
      flag_m = 1'b0;
      #1;
      chk_ctl("rst_mid", 3'b000, 1'b0, 1'b0);
      chk_res("rst_mid");
      cyc();
      RST = 1'b0;
      #1;
      chk_ctl("rst_rel", 3'b000, 1'b0, 1'b0);
      idle_cycles(5);

      // Randomized scans
      for (int n = 0; n < 12; n++) begin
         k = 9'($urandom);
         for (int i = 0; i < 3; i++)
            w[i] = ($urandom_range(0, 1) == 1) ? k : 9'($urandom);
         run_scan(3'($urandom), w[0], w[1], w[2], k,
                  1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 4)), int'($urandom_range(1, 2)),
                  int'($urandom_range(0, 2)));
      end
      idle_cycles(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Safety net so the bench can never hang
   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
